// File: rtl/tlb_op_ctrl.sv
// CP0-side sequencer for TLBP/TLBR/TLBWI/TLBWR plus the Random/Wired registers.
// Optional macro TLB_OP_WIRED_EN implements a writable Wired register; otherwise Wired reads 0.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             flush,
  output logic             op_ready,
  output logic             stall,
  output logic             done,
  input  logic [IDX_W-1:0] c0_Index,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] wired_data,
  output logic [IDX_W-1:0] Random,
  output logic [IDX_W-1:0] Wired,
  output logic [IDX_W-1:0] tlb_index,
  output logic             tlbw,
  output logic             tlbp,
  input  logic [31:0]      tlb_Index,
  input  logic [31:0]      tlb_EntryHi,
  input  logic [31:0]      tlb_EntryLo0,
  input  logic [31:0]      tlb_EntryLo1,
  output logic             wb_index_we,
  output logic [31:0]      wb_index,
  output logic             wb_entry_we,
  output logic [31:0]      wb_EntryHi,
  output logic [31:0]      wb_EntryLo0,
  output logic [31:0]      wb_EntryLo1
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_PCAP, S_READ, S_WRITE, S_DONE
  } state_e;

  localparam logic [1:0]       OP_TLBP  = 2'b00;
  localparam logic [1:0]       OP_TLBR  = 2'b01;
  localparam logic [1:0]       OP_TLBWR = 2'b11;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(TLB_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic             accept;

  assign accept = op_valid & ~flush;

  // The op code is not kept separately: the post-accept state encodes it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_ready    = 1'b0;
    stall       = 1'b1;
    done        = 1'b0;
    tlbw        = 1'b0;
    tlbp        = 1'b0;
    wb_index_we = 1'b0;
    wb_index    = '0;
    wb_entry_we = 1'b0;
    wb_EntryHi  = '0;
    wb_EntryLo0 = '0;
    wb_EntryLo1 = '0;
    tlb_index   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        op_ready  = 1'b1;
        stall     = 1'b0;
        tlb_index = c0_Index;
        if (accept) begin
          idx_d = (op_code == OP_TLBWR) ? random_q : c0_Index;
          unique case (op_code)
            OP_TLBP: state_d = S_PROBE;
            OP_TLBR: state_d = S_READ;
            default: state_d = S_WRITE;
          endcase
        end
      end
      S_PROBE: begin
        tlbp    = 1'b1;
        state_d = S_PCAP;
      end
      S_PCAP: begin
        wb_index_we = 1'b1;
        wb_index    = tlb_Index;
        state_d     = S_DONE;
      end
      S_READ: begin
        wb_entry_we = 1'b1;
        wb_EntryHi  = tlb_EntryHi;
        wb_EntryLo0 = tlb_EntryLo0;
        wb_EntryLo1 = tlb_EntryLo1;
        state_d     = S_DONE;
      end
      S_WRITE: begin
        tlbw    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TLB_OP_WIRED_EN
  logic [IDX_W-1:0] wired_q, wired_d;

  // Wired >= IDX_MAX naturally pins Random at IDX_MAX through the <= test.
  always_comb begin
    wired_d  = wired_q;
    random_d = (random_q <= wired_q) ? IDX_MAX : random_q - 1'b1;
    if (wired_we) begin
      wired_d  = wired_data;
      random_d = IDX_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wired_q <= '0;
    else      wired_q <= wired_d;
  end

  assign Wired = wired_q;
`else
  logic unused_wired;
  assign unused_wired = ^{wired_we, wired_data};

  always_comb begin
    random_d = (random_q == '0) ? IDX_MAX : random_q - 1'b1;
  end

  assign Wired = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      random_q <= IDX_MAX;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      random_q <= random_d;
    end
  end

  assign Random = random_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: expected strobe events are queued at issue and
// matched (cycle, strobes, index, write data) as the DUT emits them; Random/Wired modelled each cycle.
module tb_tlb_op_ctrl;
  localparam int IDX_W = 3;

  logic             clk, rst;
  logic             op_valid, flush, op_ready, stall, done;
  logic [1:0]       op_code;
  logic [IDX_W-1:0] c0_Index, wired_data, Random, Wired, tlb_index;
  logic             wired_we, tlbw, tlbp, wb_index_we, wb_entry_we;
  logic [31:0]      tlb_Index, tlb_EntryHi, tlb_EntryLo0, tlb_EntryLo1;
  logic [31:0]      wb_index, wb_EntryHi, wb_EntryLo0, wb_EntryLo1;

  tlb_op_ctrl #(.TLB_ENTRIES(8), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .flush(flush),
    .op_ready(op_ready), .stall(stall), .done(done), .c0_Index(c0_Index),
    .wired_we(wired_we), .wired_data(wired_data), .Random(Random), .Wired(Wired),
    .tlb_index(tlb_index), .tlbw(tlbw), .tlbp(tlbp), .tlb_Index(tlb_Index),
    .tlb_EntryHi(tlb_EntryHi), .tlb_EntryLo0(tlb_EntryLo0), .tlb_EntryLo1(tlb_EntryLo1),
    .wb_index_we(wb_index_we), .wb_index(wb_index), .wb_entry_we(wb_entry_we),
    .wb_EntryHi(wb_EntryHi), .wb_EntryLo0(wb_EntryLo0), .wb_EntryLo1(wb_EntryLo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    int               cyc;
    logic [4:0]       strb;   // {done, wb_entry_we, wb_index_we, tlbp, tlbw}
    logic [IDX_W-1:0] idx;
    logic [31:0]      wi, eh, e0, e1;
  } ev_t;

  ev_t              exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  logic [IDX_W-1:0] r_m = 3'd7;
  logic [IDX_W-1:0] w_m = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void push(input string tag, input int c, input logic [4:0] s,
                               input logic [IDX_W-1:0] i, input logic [31:0] wi,
                               input logic [31:0] eh, input logic [31:0] e0,
                               input logic [31:0] e1);
    ev_t e;
    e.tag = tag; e.cyc = c; e.strb = s; e.idx = i;
    e.wi = wi; e.eh = eh; e.e0 = e0; e.e1 = e1;
    exp_q.push_back(e);
  endfunction

  // Per-cycle monitor, 1 time unit after the active edge.
  always @(posedge clk) begin
    logic [4:0] strb;
    ev_t        e;
    #1;
    cyc++;
    if (!rst) begin
      r_m = 3'd7;
      w_m = 3'd0;
    end else begin
`ifdef TLB_OP_WIRED_EN
      if (wired_we) begin
        w_m = wired_data;
        r_m = 3'd7;
      end else if (r_m <= w_m) r_m = 3'd7;
      else r_m = r_m - 3'd1;
`else
      r_m = (r_m == 3'd0) ? 3'd7 : r_m - 3'd1;
`endif
      chk("random", Random, r_m);
      chk("wired", Wired, w_m);
      chk("stall_vs_ready", stall, !op_ready);
      chk("strobe_onehot", ($countones({tlbw, tlbp, wb_index_we, wb_entry_we}) > 1), 0);
      strb = {done, wb_entry_we, wb_index_we, tlbp, tlbw};
      if (strb != 5'b0) begin
        if (exp_q.size() == 0) chk("unexpected_event", strb, 0);
        else begin
          e = exp_q.pop_front();
          chk({e.tag, "_cycle"}, cyc, e.cyc);
          chk({e.tag, "_strobes"}, strb, e.strb);
          chk({e.tag, "_tlb_index"}, tlb_index, e.idx);
          chk({e.tag, "_stall"}, stall, 1);
          chk({e.tag, "_wb_index"}, wb_index, e.wi);
          chk({e.tag, "_wb_EntryHi"}, wb_EntryHi, e.eh);
          chk({e.tag, "_wb_EntryLo0"}, wb_EntryLo0, e.e0);
          chk({e.tag, "_wb_EntryLo1"}, wb_EntryLo1, e.e1);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic issue(input logic [1:0] code, input logic [IDX_W-1:0] c0,
                       input logic fl_in_op, input string tag);
    int               c, n;
    logic [IDX_W-1:0] idx;
    chk({tag, "_ready_at_issue"}, op_ready, 1);
    op_valid = 1'b1; op_code = code; c0_Index = c0;
    c   = cyc;
    idx = (code == 2'b11) ? r_m : c0;
    case (code)
      2'b00: begin
        push({tag, "_probe"}, c + 1, 5'b00010, idx, 0, 0, 0, 0);
        push({tag, "_pcap"},  c + 2, 5'b00100, idx, tlb_Index, 0, 0, 0);
        push({tag, "_done"},  c + 3, 5'b10000, idx, 0, 0, 0, 0);
      end
      2'b01: begin
        push({tag, "_read"}, c + 1, 5'b01000, idx, 0, tlb_EntryHi, tlb_EntryLo0, tlb_EntryLo1);
        push({tag, "_done"}, c + 2, 5'b10000, idx, 0, 0, 0, 0);
      end
      default: begin
        push({tag, "_write"}, c + 1, 5'b00001, idx, 0, 0, 0, 0);
        push({tag, "_done"},  c + 2, 5'b10000, idx, 0, 0, 0, 0);
      end
    endcase
    @(negedge clk);
    op_valid = 1'b0;
    c0_Index = ~c0;
    if (fl_in_op) flush = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b0;
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0; op_valid = 1'b0; op_code = 2'b00; flush = 1'b0; c0_Index = '0;
    wired_we = 1'b0; wired_data = '0;
    tlb_Index = '0; tlb_EntryHi = '0; tlb_EntryLo0 = '0; tlb_EntryLo1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_random", Random, 7);
    chk("rst_wired", Wired, 0);
    chk("rst_strobes", {done, tlbw, tlbp, wb_index_we, wb_entry_we}, 0);
    chk("rst_wb_index", wb_index, 0);
    rst = 1'b1;
    @(negedge clk);

    issue(2'b10, 3'd5, 1'b0, "tlbwi");
    tlb_Index = 32'h8000_0000;
    issue(2'b00, 3'd1, 1'b0, "tlbp_miss");
    tlb_Index = 32'h0000_0003;
    issue(2'b00, 3'd6, 1'b1, "tlbp_flush_probe");
    tlb_EntryHi = 32'h1234_5000; tlb_EntryLo0 = 32'h0000_1f07; tlb_EntryLo1 = 32'h0000_2e05;
    issue(2'b01, 3'd2, 1'b0, "tlbr");

    // Kill in the same cycle as the request: nothing may be accepted.
    op_valid = 1'b1; flush = 1'b1; op_code = 2'b10; c0_Index = 3'd4;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", op_ready, 1);
    repeat (3) @(negedge clk);
    chk("flush_idle_still_idle", stall, 0);

`ifdef TLB_OP_WIRED_EN
    wired_we = 1'b1; wired_data = 3'd3;
    @(negedge clk);
    wired_we = 1'b0;
`endif
    n = 0;
    while (r_m != 3'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tlbwr_wait_random4", (r_m == 3'd4), 1);
    issue(2'b11, 3'd0, 1'b0, "tlbwr");
    issue(2'b10, 3'd3, 1'b0, "tlbwi_b2b");

    // Reset in the middle of a write.
    op_valid = 1'b1; op_code = 2'b10; c0_Index = 3'd6;
    push("midrst_write", cyc + 1, 5'b00001, 3'd6, 0, 0, 0, 0);
    push("midrst_done",  cyc + 2, 5'b10000, 3'd6, 0, 0, 0, 0);
    @(negedge clk);
    op_valid = 1'b0;
    chk("midrst_tlbw_before", tlbw, 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_tlbw", tlbw, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_random", Random, 7);
    chk("midrst_wired", Wired, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", op_ready, 1);
    repeat (12) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
